bus_invert_decoder: RTL

- Receive-side decoder for bus-invert coded data. Each beat carries a data word plus an invert flag. When the flag is set, the block restores the original word by bitwise inversion.
- Sits between the bus-invert link and the processor datapath. It is registered, uses a valid/ready handshake on both sides, and has a 2-entry skid buffer so upstream sees a registered ready.
- Keeps a saturating count of inverted beats for link-activity statistics.

---
 rtl/proc_pkg.sv | 15 +
 rtl/skid_buffer2.sv | 89 ++++++++
 rtl/bus_invert_decoder.sv | 70 +++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the bus-invert encoder/decoder pair: the buffer
// state encoding and the default data and counter widths.
package proc_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 16;

  // Occupancy of the 2-entry skid buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/skid_buffer2.sv
// Generic 2-entry valid/ready skid buffer. The main register drives out_data;
// the skid register absorbs one extra beat so in_ready can be a flop.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   in_valid/in_data/in_ready    upstream handshake (in_ready registered)
//   out_valid/out_data/out_ready downstream handshake (outputs registered)
module skid_buffer2
  import proc_pkg::*;
#(
  parameter int unsigned W = DATA_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  buf_state_e   state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         out_valid_q, out_valid_d;
  logic         in_ready_q, in_ready_d;
  logic         accept_c, xfer_c;

  assign accept_c = in_valid & in_ready_q;
  assign xfer_c   = out_valid_q & out_ready;

  // State, storage and handshake registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Next-state and storage steering.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept_c) begin
          state_d = ST_ONE;
          main_d  = in_data;
        end
      end
      ST_ONE: begin
        if (accept_c && xfer_c) begin
          main_d = in_data;
        end else if (xfer_c) begin
          state_d = ST_EMPTY;
        end else if (accept_c) begin
          state_d = ST_FULL;
          skid_d  = in_data;
        end
      end
      ST_FULL: begin
        if (xfer_c) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Handshake flops are computed from the next state so they are valid
    // in the same cycle the state register takes effect.
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

endmodule

// File: rtl/bus_invert_decoder.sv
// Receive-side bus-invert decoder. Words are restored at capture into a
// 2-entry skid buffer; a saturating counter tracks accepted inverted beats.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_data/in_inv    coded upstream beat; in_ready registered
//   out_valid/out_data         decoded beat, out_ready from downstream
//   count_clr                  synchronous clear of inv_count (has priority)
//   inv_count                  saturating count of accepted inverted beats
module bus_invert_decoder
  import proc_pkg::*;
#(
  parameter int unsigned W     = DATA_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  input  logic             in_inv,
  output logic             in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  input  logic             out_ready,
  input  logic             count_clr,
  output logic [CNT_W-1:0] inv_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [W-1:0]     decoded_c;
  logic             accept_c;
  logic [CNT_W-1:0] inv_count_q, inv_count_d;

  assign decoded_c = in_inv ? ~in_data : in_data;
  assign accept_c  = in_valid & in_ready;

  skid_buffer2 #(
    .W(W)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (decoded_c),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready)
  );

  // Inverted-beat counter: clear wins over increment, saturates at all-ones.
  always_comb begin
    inv_count_d = inv_count_q;
    if (count_clr) begin
      inv_count_d = '0;
    end else if (accept_c && in_inv && (inv_count_q != CNT_MAX)) begin
      inv_count_d = inv_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inv_count_q <= '0;
    end else begin
      inv_count_q <= inv_count_d;
    end
  end

  assign inv_count = inv_count_q;

endmodule
